instr_fetch: RTL and testbench

Instruction fetch stage of the RV32I core, directly upstream of the instruction decoder. It owns the program counter and issues word fetches to instruction memory over a request/acknowledge plus in-order response interface. Returned words are buffered with their PC and presented to the decoder through a valid/ready handshake. Taken branches and jumps redirect the PC and discard wrong-path instructions, both buffered and in flight.

---
 rtl/fetch_pkg.sv | 43 ++++
 rtl/fetch_fifo.sv | 90 +++++++++
 rtl/instr_fetch.sv | 170 +++++++++++++++++
 tb/tb_instr_fetch.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the RV32I fetch stage: the NOP filler word, the fetch
// FSM state encoding, base opcodes shared with the decoder and small PC helpers.
package fetch_pkg;

    // Canonical RV32I NOP (addi x0, x0, 0), presented while the buffer is empty
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    // Fetch control states
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

    // RV32I base opcodes (inst[6:0]), shared with the decoder
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // Extract the base opcode field of an instruction word
    function automatic logic [6:0] inst_opcode(input logic [31:0] inst);
        return inst[6:0];
    endfunction

    // Force a target address onto a word boundary
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    // Sequential PC step; wraps from 32'hFFFF_FFFC to 0 by natural overflow
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: synchronous FIFO of {pc, inst} records. Storage is an
// array with a registered read into an output register, so a word pushed at
// one edge becomes visible at the output after the next edge. The reported
// count includes the output register, so DEPTH is the true total capacity.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_clear,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic                     o_valid,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty,
    output logic                     o_full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_mem_count;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;

    logic             w_pop;
    logic             w_push;
    logic             w_load;
    logic             w_full;
    logic [AW:0]      w_count;

    assign w_count = r_mem_count + (AW + 1)'(r_out_valid);
    assign w_full  = (w_count == FULL_COUNT);

    // A pop only means something when the output register holds a word.
    assign w_pop  = i_pop & r_out_valid;
    // Push into a full buffer is accepted only when a pop frees a slot.
    assign w_push = i_push & (~w_full | w_pop);
    // Refill the output register from storage whenever it is, or is becoming, free.
    assign w_load = (r_mem_count != '0) & (~r_out_valid | w_pop);

    // Storage write port; the array carries no reset so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (w_push && !i_clear) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers, occupancy and the registered read/output stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_mem_count <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (i_clear) begin
            // Output data is kept so the last PC stays visible after a flush.
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_mem_count <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_load) begin
                r_rd_ptr    <= r_rd_ptr + AW'(1);
                r_out_data  <= r_mem[r_rd_ptr];
                r_out_valid <= 1'b1;
            end else if (w_pop) begin
                r_out_valid <= 1'b0;
            end
            r_mem_count <= r_mem_count + (AW + 1)'(w_push) - (AW + 1)'(w_load);
        end
    end

    assign o_valid = r_out_valid;
    assign o_data  = r_out_data;
    assign o_count = w_count;
    assign o_empty = (w_count == '0);
    assign o_full  = w_full;

endmodule

// File: rtl/instr_fetch.sv
// RV32I instruction fetch stage. Owns the PC, issues word fetches over a
// req/ack + in-order response interface, buffers returned words with their PC
// and hands them to the decoder over valid/ready. Redirects reload the PC and
// discard both buffered and in-flight wrong-path words.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_inst_valid,
    output logic [31:0] o_inst,
    output logic [31:0] o_inst_pc,
    input  logic        i_inst_ready
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_LIM = (CW + 1)'(DEPTH);

    // Architectural / control registers
    fetch_state_t   r_state;
    logic [31:0]    r_pc;          // next fetch address (drives o_imem_addr)
    logic [31:0]    r_rsp_pc;      // PC of the next response to be buffered
    logic [CW-1:0]  r_outstanding; // accepted requests without a response yet
    logic [CW-1:0]  r_discard;     // stale responses still to be dropped
    logic           r_imem_req;

    // Next-state values
    fetch_state_t   w_state_next;
    logic [31:0]    w_pc_next;
    logic [31:0]    w_rsp_pc_next;
    logic [CW-1:0]  w_discard_next;
    logic [CW-1:0]  w_out_next;
    logic [CW-1:0]  w_cnt_next;
    logic           w_req_next;

    // Handshake decodes and buffer interface
    logic           w_fire;
    logic           w_rsp;
    logic           w_push;
    logic           w_pop;
    logic           w_fifo_valid;
    logic [63:0]    w_fifo_data;
    logic [CW-1:0]  w_fifo_count;
    logic           w_fifo_empty;
    logic           w_fifo_full;

    assign w_fire = r_imem_req & i_imem_ack;
    // A response with nothing outstanding is a protocol error and is ignored.
    assign w_rsp  = i_imem_rvalid & (r_outstanding != '0);
    assign w_pop  = w_fifo_valid & i_inst_ready;
    // Only responses arriving in FETCH are right-path; a same-cycle redirect kills them.
    assign w_push = w_rsp & (r_state == FETCH) & ~i_redirect & (~w_fifo_full | w_pop);

    assign w_out_next = r_outstanding + CW'(w_fire) - CW'(w_rsp);
    // Buffer occupancy after this edge; a redirect empties it.
    assign w_cnt_next = i_redirect ? '0 : (w_fifo_count + CW'(w_push) - CW'(w_pop));

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (i_redirect),
        .i_push      (w_push),
        .i_push_data ({r_rsp_pc, i_imem_rdata}),
        .i_pop       (w_pop),
        .o_valid     (w_fifo_valid),
        .o_data      (w_fifo_data),
        .o_count     (w_fifo_count),
        .o_empty     (w_fifo_empty),
        .o_full      (w_fifo_full)
    );

    // Next-state logic for PC, response PC, discard count and FSM state.
    always_comb begin
        w_state_next   = r_state;
        w_pc_next      = r_pc;
        w_rsp_pc_next  = r_rsp_pc;
        w_discard_next = r_discard;
        if (i_redirect) begin
            w_pc_next     = word_align(i_redirect_pc);
            w_rsp_pc_next = word_align(i_redirect_pc);
            if (r_state == FLUSH) begin
                // Already flushing: the stale count carries over, minus any drop now.
                w_discard_next = r_discard - CW'(w_rsp);
            end else begin
                // Everything still in flight after this edge is wrong-path,
                // including a request acknowledged in this very cycle.
                w_discard_next = w_out_next;
            end
            w_state_next = (w_discard_next != '0) ? FLUSH : FETCH;
        end else begin
            case (r_state)
                BOOT: begin
                    w_state_next = FETCH;
                end
                FETCH: begin
                    if (w_fire) begin
                        w_pc_next = pc_plus4(r_pc);
                    end
                    if (w_push) begin
                        w_rsp_pc_next = pc_plus4(r_rsp_pc);
                    end
                end
                FLUSH: begin
                    if (w_rsp) begin
                        w_discard_next = r_discard - CW'(1);
                    end
                    if (w_discard_next == '0) begin
                        w_state_next = FETCH;
                    end
                end
                default: begin
                    w_state_next = BOOT;
                end
            endcase
        end
        // Request is registered: issue only while in-flight plus buffered words
        // leave room, so the buffer can never overflow.
        w_req_next = (w_state_next == FETCH) &&
                     (({1'b0, w_out_next} + {1'b0, w_cnt_next}) < DEPTH_LIM);
    end

    // Fetch FSM and control registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= BOOT;
            r_pc          <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_imem_req    <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_pc          <= w_pc_next;
            r_rsp_pc      <= w_rsp_pc_next;
            r_outstanding <= w_out_next;
            r_discard     <= w_discard_next;
            r_imem_req    <= w_req_next;
        end
    end

    assign o_imem_req   = r_imem_req;
    assign o_imem_addr  = r_pc;
    assign o_inst_valid = w_fifo_valid;
    assign o_inst       = w_fifo_valid ? w_fifo_data[31:0] : NOP_INST;
    assign o_inst_pc    = w_fifo_data[63:32];

    // Simulation-only check: memory must never respond without a pending request.
    assert property (@(posedge clk) disable iff (rst)
                     !(i_imem_rvalid && (r_outstanding == '0)))
        else $error("instr_fetch: imem_rvalid with no fetch outstanding");

    // Simulation-only check: an empty buffer never presents a valid instruction.
    assert property (@(posedge clk) disable iff (rst)
                     !(w_fifo_empty && w_fifo_valid))
        else $error("instr_fetch: buffer empty while output valid");

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a small in-order memory model with
// configurable latency, a redirect vector table and hand-written sequences
// for start-up, back-pressure, flushes and mid-stream reset.
module tb_instr_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic        rvalid;
    logic [31:0] rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;

    instr_fetch #(
        .RESET_PC (32'h0000_0100),
        .DEPTH    (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .o_imem_req    (req),
        .o_imem_addr   (addr),
        .i_imem_ack    (ack),
        .i_imem_rvalid (rvalid),
        .i_imem_rdata  (rdata),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .o_inst_valid  (inst_valid),
        .o_inst        (inst),
        .o_inst_pc     (inst_pc),
        .i_inst_ready  (inst_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Memory model state
    int          cyc;
    int          lat;
    bit          ack_en;
    logic [31:0] q_addr [$];
    int          q_due  [$];
    bit          last_fire;
    bit          last_rvalid;

    // Logs of accepted fetch addresses and delivered instructions
    logic [31:0] f_addr   [$];
    logic [31:0] del_pc   [$];
    logic [31:0] del_inst [$];

    typedef struct {
        logic [31:0] rpc;
        logic [31:0] exp_addr;
        logic [31:0] exp_next;
    } vec_t;
    vec_t vecs [6];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            $display("[TB] ok   %s = %h", name, act);
        end
    endtask

    task automatic clear_logs();
        f_addr.delete();
        del_pc.delete();
        del_inst.delete();
    endtask

    // One clock cycle, entered and left at a falling edge (the sample point).
    task automatic tick();
        ack = ack_en && req;
        if (q_addr.size() > 0 && q_due[0] <= cyc) begin
            rvalid = 1'b1;
            rdata  = mem_word(q_addr[0]);
        end else begin
            rvalid = 1'b0;
            rdata  = '0;
        end
        last_fire   = req && ack;
        last_rvalid = rvalid;
        if (req && ack) begin
            q_addr.push_back(addr);
            q_due.push_back(cyc + lat);
            f_addr.push_back(addr);
        end
        if (rvalid) begin
            void'(q_addr.pop_front());
            void'(q_due.pop_front());
        end
        if (inst_valid && inst_ready) begin
            del_pc.push_back(inst_pc);
            del_inst.push_back(inst);
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic model_idle();
        ack      = 1'b0;
        rvalid   = 1'b0;
        rdata    = '0;
        redirect = 1'b0;
        q_addr.delete();
        q_due.delete();
        clear_logs();
    endtask

    // Hold reset for two cycles; returns at the first sample point after release.
    task automatic do_reset();
        rst = 1'b1;
        model_idle();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic wait_deliver(input int max_cyc, input string name);
        int n = 0;
        while (del_pc.size() == 0 && n < max_cyc) begin
            tick();
            n++;
        end
        if (del_pc.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL %s: no instruction delivered within %0d cycles", name, max_cyc);
        end
    endtask

    task automatic wait_fetch(input int need, input int max_cyc, input string name);
        int n = 0;
        while (f_addr.size() < need && n < max_cyc) begin
            tick();
            n++;
        end
        if (f_addr.size() < need) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL %s: only %0d fetches within %0d cycles", name, f_addr.size(), max_cyc);
        end
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'h0000_0203, 32'h0000_0200, 32'h0000_0204};
        vecs[1] = '{32'h0000_1000, 32'h0000_1000, 32'h0000_1004};
        vecs[2] = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000};
        vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0000_0000};
        vecs[4] = '{32'h0000_0007, 32'h0000_0004, 32'h0000_0008};
        vecs[5] = '{32'h1234_5679, 32'h1234_5678, 32'h1234_567C};

        rst = 1'b1; redirect_pc = '0; inst_ready = 1'b1;
        ack_en = 1'b1; lat = 1; cyc = 0;
        model_idle();

        // ---- Reset values and start-up with 1-cycle memory ----
        @(negedge clk);
        check("reset_req",        32'(req),        32'd0);
        check("reset_addr",       addr,            32'h100);
        check("reset_inst_valid", 32'(inst_valid), 32'd0);
        check("reset_inst",       inst,            NOP);
        check("reset_inst_pc",    inst_pc,         32'h0);
        do_reset();
        check("boot_req", 32'(req), 32'd0);
        tick();
        check("s1_req",  32'(req), 32'd1);
        check("s1_addr", addr,     32'h100);
        tick();
        check("s2_addr", addr, 32'h104);
        tick();
        check("s3_inst_valid", 32'(inst_valid), 32'd0);
        tick();
        // Response to 100 accepted at edge 3, visible after edge 4
        check("s4_inst_valid", 32'(inst_valid), 32'd1);
        check("s4_inst_pc",    inst_pc,         32'h100);
        check("s4_inst",       inst,            mem_word(32'h100));
        tick();
        check("s5_inst_pc", inst_pc, 32'h104);
        clear_logs();
        repeat (16) tick();
        check("tput_fetches",   32'(f_addr.size()), 32'd16);
        check("tput_delivered", 32'(del_pc.size()), 32'd16);
        for (int i = 0; i < del_pc.size(); i++) begin
            check($sformatf("tput_pc_%0d", i), del_pc[i], 32'h104 + 32'(4 * i));
        end

        // ---- Back-pressure: decoder stalls for 10+ cycles ----
        inst_ready = 1'b0;
        do_reset();
        repeat (12) tick();
        check("bp_fetch_count", 32'(f_addr.size()), 32'd4);
        check("bp_req_low",     32'(req),           32'd0);
        check("bp_inst_valid",  32'(inst_valid),    32'd1);
        clear_logs();
        inst_ready = 1'b1;
        repeat (4) tick();
        check("bp_b2b_count", 32'(del_pc.size()), 32'd4);
        for (int i = 0; i < del_pc.size(); i++) begin
            check($sformatf("bp_b2b_pc_%0d", i), del_pc[i], 32'h100 + 32'(4 * i));
        end
        wait_fetch(1, 6, "bp_resume");
        if (f_addr.size() > 0) check("bp_resume_addr", f_addr[0], 32'h110);

        // ---- Latency 3, two fetches in flight, redirect to 200 ----
        lat = 3;
        do_reset();
        ack_en = 1'b1;
        tick();                 // boot cycle
        tick();                 // fetch 100
        tick();                 // fetch 104
        ack_en = 1'b0;
        redirect = 1'b1; redirect_pc = 32'h200;
        tick();
        redirect = 1'b0;
        check("fl_req_s4",  32'(req), 32'd0);
        check("fl_addr_s4", addr,     32'h200);
        tick();                 // stale 100 dropped
        check("fl_req_s5", 32'(req), 32'd0);
        tick();                 // stale 104 dropped
        check("fl_req_s6",        32'(req),        32'd1);
        check("fl_inst_valid_s6", 32'(inst_valid), 32'd0);
        clear_logs();
        ack_en = 1'b1;
        wait_deliver(12, "fl_first");
        if (del_pc.size() > 0) begin
            check("fl_first_pc",   del_pc[0],   32'h200);
            check("fl_first_inst", del_inst[0], mem_word(32'h200));
        end

        // ---- Redirect in the same cycle as ack and rvalid ----
        lat = 1;
        do_reset();
        ack_en = 1'b1;
        repeat (8) tick();
        redirect = 1'b1; redirect_pc = 32'h300;
        tick();
        redirect = 1'b0;
        check("sc_pre_fire",   32'(last_fire),   32'd1);
        check("sc_pre_rvalid", 32'(last_rvalid), 32'd1);
        check("sc_inst_valid", 32'(inst_valid),  32'd0);
        check("sc_req_flush",  32'(req),         32'd0);
        check("sc_addr",       addr,             32'h300);
        clear_logs();
        wait_deliver(10, "sc_first");
        if (del_pc.size() > 0) begin
            check("sc_first_pc",   del_pc[0],   32'h300);
            check("sc_first_inst", del_inst[0], mem_word(32'h300));
        end

        // ---- Redirect target table: alignment and PC wrap ----
        for (int v = 0; v < 6; v++) begin
            ack_en = 1'b0;
            repeat (4) tick();
            redirect = 1'b1; redirect_pc = vecs[v].rpc;
            tick();
            redirect = 1'b0;
            check($sformatf("tbl%0d_addr", v), addr,     vecs[v].exp_addr);
            check($sformatf("tbl%0d_req", v),  32'(req), 32'd1);
            clear_logs();
            ack_en = 1'b1;
            tick();
            ack_en = 1'b0;
            check($sformatf("tbl%0d_next", v), addr, vecs[v].exp_next);
            wait_deliver(8, $sformatf("tbl%0d_deliver", v));
            if (del_pc.size() > 0) begin
                check($sformatf("tbl%0d_pc", v),   del_pc[0],   vecs[v].exp_addr);
                check($sformatf("tbl%0d_inst", v), del_inst[0], mem_word(vecs[v].exp_addr));
            end
        end

        // ---- Asynchronous reset mid-stream with a full buffer ----
        inst_ready = 1'b0;
        ack_en = 1'b1;
        do_reset();
        repeat (10) tick();
        check("mr_pre_valid", 32'(inst_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mr_req",        32'(req),        32'd0);
        check("mr_addr",       addr,            32'h100);
        check("mr_inst_valid", 32'(inst_valid), 32'd0);
        check("mr_inst",       inst,            NOP);
        model_idle();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        inst_ready = 1'b1;
        wait_fetch(1, 6, "mr_restart");
        if (f_addr.size() > 0) check("mr_restart_addr", f_addr[0], 32'h100);
        wait_deliver(8, "mr_deliver");
        if (del_pc.size() > 0) check("mr_first_pc", del_pc[0], 32'h100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
